// File: rtl/wta_out_if.sv
// Record bus from the WTA decoder to downstream binary logic.
// The master drives the record and out_valid; the slave drives out_ready.
interface wta_out_if #(
  parameter int TW = 4,
  parameter int IW = 4
) ();
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic [TW-1:0] out_time;
  logic          out_none;

  modport master (
    output out_valid,
    output out_idx,
    output out_time,
    output out_none,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_time,
    input  out_none,
    output out_ready
  );
endinterface

// File: rtl/wta_decoder.sv
// WTA decoder: turns each gamma cycle's temporally encoded winner spike into a
// binary record (winner index, spike time, no-spike flag) on a valid/ready bus.
module wta_decoder #(
  parameter int Q  = 10,
  parameter int TW = 4,
  localparam int IW = (Q > 1) ? $clog2(Q) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         grst,
  input  logic [Q-1:0] spikes_in,
  wta_out_if.master    out,
  output logic         overrun
);

  localparam logic [TW-1:0] TIME_MAX = '1;

  typedef enum logic {ARMED, CAPTURED} cap_state_t;
  typedef enum logic {EMPTY, FULL}     out_state_t;

  // Index of the lowest set bit; ties between lines go to the lowest index.
  function automatic logic [IW-1:0] lowest_idx(input logic [Q-1:0] v);
    lowest_idx = '0;
    for (int i = Q - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IW'(i);
    end
  endfunction

  logic [Q-1:0]  prev;
  logic [Q-1:0]  rise;
  logic [TW-1:0] counter;
  logic [TW-1:0] cur_time;
  logic          started;

  cap_state_t    cap_state, cap_next;
  logic [IW-1:0] cap_idx, cap_idx_next;
  logic [TW-1:0] cap_time, cap_time_next;

  out_state_t    out_state, out_next;
  logic [IW-1:0] rec_idx, held_idx;
  logic [TW-1:0] rec_time, held_time;
  logic          rec_none, held_none;
  logic          commit, accept, load, drop;

  // Only fresh rising edges count, so a pulse straddling grst is not re-seen.
  assign rise     = spikes_in & ~prev;
  // The grst cycle itself is time 0 of the new window.
  assign cur_time = grst ? '0 : counter;
  // The first grst after reset only opens a window; it has nothing to commit.
  assign commit   = grst & started;

  // Edge history, gamma time base (saturating) and started flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      counter <= '0;
      started <= 1'b0;
    end else begin
      prev <= spikes_in;
      if (grst) begin
        counter <= TW'(1);
        started <= 1'b1;
      end else if (counter != TIME_MAX) begin
        counter <= counter + TW'(1);
      end
    end
  end

  // Capture FSM state and latched winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_state <= ARMED;
      cap_idx   <= '0;
      cap_time  <= '0;
    end else begin
      cap_state <= cap_next;
      cap_idx   <= cap_idx_next;
      cap_time  <= cap_time_next;
    end
  end

  // Capture next-state: grst restarts the window (and may capture at time 0),
  // otherwise the first rise of an armed window is latched.
  always_comb begin
    cap_next      = cap_state;
    cap_idx_next  = cap_idx;
    cap_time_next = cap_time;
    if (grst) begin
      if (|rise) begin
        cap_next      = CAPTURED;
        cap_idx_next  = lowest_idx(rise);
        cap_time_next = '0;
      end else begin
        cap_next      = ARMED;
        cap_idx_next  = '0;
        cap_time_next = '0;
      end
    end else if ((cap_state == ARMED) && (|rise)) begin
      cap_next      = CAPTURED;
      cap_idx_next  = lowest_idx(rise);
      cap_time_next = cur_time;
    end else begin
      cap_next = cap_state;
    end
  end

  // Record for the window that ends at this grst (uses the old capture).
  always_comb begin
    rec_none = 1'b1;
    rec_idx  = '0;
    rec_time = '0;
    if (cap_state == CAPTURED) begin
      rec_none = 1'b0;
      rec_idx  = cap_idx;
      rec_time = cap_time;
    end else begin
      rec_none = 1'b1;
    end
  end

  // Output register next-state: load on commit when empty or being drained,
  // drop and flag overrun when the held record is stalled.
  always_comb begin
    out_next = out_state;
    load     = 1'b0;
    drop     = 1'b0;
    accept   = (out_state == FULL) && out.out_ready;
    case (out_state)
      EMPTY: begin
        if (commit) begin
          load     = 1'b1;
          out_next = FULL;
        end else begin
          out_next = EMPTY;
        end
      end
      FULL: begin
        if (accept) begin
          if (commit) begin
            load     = 1'b1;
            out_next = FULL;
          end else begin
            out_next = EMPTY;
          end
        end else if (commit) begin
          drop = 1'b1;
        end else begin
          out_next = FULL;
        end
      end
      default: out_next = EMPTY;
    endcase
  end

  // Output register state, held record and overrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state <= EMPTY;
      held_idx  <= '0;
      held_time <= '0;
      held_none <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_state <= out_next;
      overrun   <= drop;
      if (load) begin
        held_idx  <= rec_idx;
        held_time <= rec_time;
        held_none <= rec_none;
      end
    end
  end

  assign out.out_valid = (out_state == FULL);
  assign out.out_idx   = held_idx;
  assign out.out_time  = held_time;
  assign out.out_none  = held_none;

endmodule

// File: tb/tb_wta_decoder.sv
// Self-checking bench for wta_decoder: directed scenarios with fixed expected
// records, then randomized traffic checked against a window-level model.
module tb_wta_decoder;
  localparam int Q  = 10;
  localparam int TW = 4;
  localparam int IW = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         grst;
  logic [Q-1:0] spikes_in;
  logic         overrun;

  wta_out_if #(.TW(TW), .IW(IW)) bus ();

  wta_decoder #(.Q(Q), .TW(TW)) dut (
    .clk(clk),
    .rst(rst),
    .grst(grst),
    .spikes_in(spikes_in),
    .out(bus),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one window at a time, earliest rising edge wins.
  logic [Q-1:0] m_prev;
  bit           m_started, m_found, m_valid, m_ovr, e_none;
  int           m_idx, m_time, m_since, e_idx, e_time;
  logic [9:0]   got;

  task automatic model_reset();
    m_prev = '0; m_started = 0; m_found = 0; m_valid = 0; m_ovr = 0;
    m_idx = 0; m_time = 0; m_since = 0; e_idx = 0; e_time = 0; e_none = 0;
  endtask

  // Apply one cycle of inputs, clock it, advance the model, settle 1 time unit.
  task automatic step(input logic g, input logic [Q-1:0] sp, input logic rdy);
    int lo;
    bit acc, com, c_none;
    int c_idx, c_time;
    lo = -1; com = 0; c_none = 0; c_idx = 0; c_time = 0;
    grst = g; spikes_in = sp; bus.out_ready = rdy;
    @(posedge clk);
    for (int i = 0; i < Q; i++) if (sp[i] && !m_prev[i] && lo < 0) lo = i;
    m_prev = sp;
    acc = m_valid && rdy;
    if (g) begin
      com = m_started;
      c_none = !m_found;
      c_idx = m_found ? m_idx : 0;
      c_time = m_found ? m_time : 0;
      m_started = 1; m_since = 0;
      m_found = (lo >= 0); m_idx = (lo >= 0) ? lo : 0; m_time = 0;
    end else begin
      if (m_since < 1000) m_since++;
      if (!m_found && lo >= 0) begin
        m_found = 1; m_idx = lo; m_time = (m_since > TMAX) ? TMAX : m_since;
      end
    end
    m_ovr = 0;
    if (com) begin
      if (!m_valid || acc) begin
        m_valid = 1; e_idx = c_idx; e_time = c_time; e_none = c_none;
      end else begin
        m_ovr = 1;
      end
    end else if (acc) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic run(input int n, input logic [Q-1:0] sp, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, sp, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1; grst = 1'b0; spikes_in = '0; bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; grst = 1'b0; spikes_in = '0; bus.out_ready = 1'b0;
    #3;
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== 10'd0 || overrun !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: got rec=%b ovr=%b, want all 0", got, overrun);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, '0, 1'b1);
    run(4, '0, 1'b1);
    step(1'b1, '0, 1'b1);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b1, 4'd0, 4'd0}) begin
      n_bad++; $display("FAIL basic_empty_window: got %b want %b", got, {1'b1, 1'b1, 4'd0, 4'd0});
    end
    run(6, '0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle_valid: got %b want 0", bus.out_valid);
    end
    run(4, 10'd1 << 6, 1'b1);
    run(4, '0, 1'b1);
    step(1'b1, '0, 1'b1);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 4'd6, 4'd7}) begin
      n_bad++; $display("FAIL basic_record: got %b want %b", got, {1'b1, 1'b0, 4'd6, 4'd7});
    end
    step(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_single_cycle: got valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_tie();
    do_reset();
    step(1'b1, '0, 1'b1);
    run(2, '0, 1'b1);
    run(2, 10'b0010000100, 1'b1);
    step(1'b0, 10'b0010000101, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, '0, 1'b1);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 4'd2, 4'd3}) begin
      n_bad++; $display("FAIL tie_lowest: got %b want %b", got, {1'b1, 1'b0, 4'd2, 4'd3});
    end
  endtask

  task automatic test_straddle();
    do_reset();
    step(1'b1, '0, 1'b1);
    run(8, '0, 1'b1);
    run(3, 10'd1 << 4, 1'b1);
    step(1'b1, 10'd1 << 4, 1'b1);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 4'd4, 4'd9}) begin
      n_bad++; $display("FAIL straddle_first: got %b want %b", got, {1'b1, 1'b0, 4'd4, 4'd9});
    end
    run(2, 10'd1 << 4, 1'b1);
    run(3, '0, 1'b1);
    step(1'b1, '0, 1'b1);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b1, 4'd0, 4'd0}) begin
      n_bad++; $display("FAIL straddle_none: got %b want %b", got, {1'b1, 1'b1, 4'd0, 4'd0});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b1, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, 10'd1 << 3, 1'b0);
    run(3, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 4'd3, 4'd2} || overrun !== 1'b0) begin
      n_bad++; $display("FAIL bp_first: got %b ovr %b want %b ovr 0", got, overrun, {1'b1, 1'b0, 4'd3, 4'd2});
    end
    step(1'b0, '0, 1'b0);
    step(1'b0, 10'd1 << 5, 1'b0);
    run(3, '0, 1'b0);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 4'd3, 4'd2}) begin
      n_bad++; $display("FAIL bp_hold: got %b want %b", got, {1'b1, 1'b0, 4'd3, 4'd2});
    end
    step(1'b1, '0, 1'b0);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (overrun !== 1'b1 || got !== {1'b1, 1'b0, 4'd3, 4'd2}) begin
      n_bad++; $display("FAIL bp_overrun: got ovr %b rec %b want ovr 1 rec %b", overrun, got, {1'b1, 1'b0, 4'd3, 4'd2});
    end
    step(1'b0, '0, 1'b0);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (overrun !== 1'b0 || got !== {1'b1, 1'b0, 4'd3, 4'd2}) begin
      n_bad++; $display("FAIL bp_overrun_pulse: got ovr %b rec %b want ovr 0 rec %b", overrun, got, {1'b1, 1'b0, 4'd3, 4'd2});
    end
    step(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_single_transfer: got valid %b want 0", bus.out_valid);
    end
    step(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_no_second: got valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_edge();
    do_reset();
    step(1'b1, '0, 1'b1);
    run(3, '0, 1'b1);
    step(1'b1, 10'd1 << 1, 1'b1);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b1, 4'd0, 4'd0}) begin
      n_bad++; $display("FAIL edge_old_window: got %b want %b", got, {1'b1, 1'b1, 4'd0, 4'd0});
    end
    run(2, 10'd1 << 1, 1'b1);
    run(2, '0, 1'b1);
    step(1'b1, '0, 1'b1);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 4'd1, 4'd0}) begin
      n_bad++; $display("FAIL edge_time0: got %b want %b", got, {1'b1, 1'b0, 4'd1, 4'd0});
    end
    run(19, '0, 1'b1);
    step(1'b0, 10'd1 << 8, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, '0, 1'b1);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 4'd8, 4'd15}) begin
      n_bad++; $display("FAIL edge_saturate: got %b want %b", got, {1'b1, 1'b0, 4'd8, 4'd15});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, 10'd1 << 9, 1'b0);
    run(2, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 4'd9, 4'd2}) begin
      n_bad++; $display("FAIL rmid_record: got %b want %b", got, {1'b1, 1'b0, 4'd9, 4'd2});
    end
    step(1'b0, 10'd1 << 5, 1'b0);
    rst = 1'b1; spikes_in = '0;
    #2;
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== 10'd0 || overrun !== 1'b0) begin
      n_bad++; $display("FAIL rmid_clear: got rec=%b ovr=%b want all 0", got, overrun);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b1, '0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_first_grst: got valid %b want 0", bus.out_valid);
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, 10'd1 << 0, 1'b1);
    step(1'b1, '0, 1'b1);
    got = {bus.out_valid, bus.out_none, bus.out_idx, bus.out_time};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 4'd0, 4'd2}) begin
      n_bad++; $display("FAIL rmid_next_record: got %b want %b", got, {1'b1, 1'b0, 4'd0, 4'd2});
    end
  endtask

  task automatic test_random();
    logic [Q-1:0] sp;
    logic         g, rdy;
    int           busy;
    do_reset();
    sp = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
        sp = '0;
      end
      busy = (c / 200) % 2;
      g = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < Q; b++) if ($urandom_range(0, 15) == 0) sp[b] = ~sp[b];
      rdy = busy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      step(g, sp, rdy);
      n_cmp++;
      if (bus.out_valid !== m_valid) begin
        n_bad++; $display("FAIL rand_valid c=%0d: got %b want %b", c, bus.out_valid, m_valid);
      end
      n_cmp++;
      if (overrun !== m_ovr) begin
        n_bad++; $display("FAIL rand_overrun c=%0d: got %b want %b", c, overrun, m_ovr);
      end
      if (m_valid) begin
        n_cmp++;
        if (bus.out_idx !== IW'(e_idx) || bus.out_time !== TW'(e_time) || bus.out_none !== e_none) begin
          n_bad++;
          $display("FAIL rand_record c=%0d: got idx %0d time %0d none %b want idx %0d time %0d none %b",
                   c, bus.out_idx, bus.out_time, bus.out_none, e_idx, e_time, e_none);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_tie();
    test_straddle();
    test_backpressure();
    test_edge();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
